// File: rtl/vec_mem_pkg.sv
// vec_mem_pkg: shared constants, types and range helper for the vector memory sequencer
package vec_mem_pkg;
  localparam int LANES = 6;
  localparam int LANE_W = 8;
  localparam int MEM_WORDS = 102;
  localparam int LEN_W = 8;
  typedef logic [LANES-1:0][LANE_W-1:0] vec_t;
  typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} seq_state_t;
  function automatic logic word_in_range(input logic [31:0] addr, input int unsigned mem_words);
    return (addr[31:14] == '0) && ({20'b0, addr[13:2]} < mem_words);
  endfunction
endpackage

// File: rtl/vec_out_reg.sv
// vec_out_reg: one-entry valid/ready output register for the load data path
module vec_out_reg #(
  parameter int W = 48
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         out_ready,
  output logic         can_load,
  output logic         out_valid,
  output logic [W-1:0] out_data
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  // a new beat may enter when empty or when the held beat leaves this cycle
  always_comb begin
    can_load = !valid_q || out_ready;
    valid_d = load || (valid_q && !out_ready);
    data_d = load ? load_data : data_q;
    out_valid = valid_q;
    out_data = data_q;
  end
  // holding register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q <= data_d;
    end
  end
endmodule

// File: rtl/vec_mem_seq.sv
// vec_mem_seq: burst load/store sequencer driving the vector data memory port
module vec_mem_seq #(
  parameter int LANES = vec_mem_pkg::LANES,
  parameter int LANE_W = vec_mem_pkg::LANE_W,
  parameter int MEM_WORDS = vec_mem_pkg::MEM_WORDS,
  parameter int LEN_W = vec_mem_pkg::LEN_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [31:0]             req_base,
  input  logic [LEN_W-1:0]        req_len,
  input  logic [7:0]              req_stride,
  input  logic                    wd_valid,
  output logic                    wd_ready,
  input  logic [LANES*LANE_W-1:0] wd_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [LANES*LANE_W-1:0] rd_data,
  output logic                    done,
  output logic                    err,
  output logic [31:0]             mem_A,
  output logic                    mem_WE,
  output logic [LANES*LANE_W-1:0] mem_WD,
  input  logic [LANES*LANE_W-1:0] mem_RD
);
  import vec_mem_pkg::*;
  localparam int W = LANES*LANE_W;
  seq_state_t       state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [7:0]       stride_q, stride_d;
  logic             err_q, err_d;
  logic             in_range, can_cap, cap, step;
  logic [W-1:0]     cap_data;

  vec_out_reg #(.W(W)) u_out (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cap),
    .load_data(cap_data),
    .out_ready(rd_ready),
    .can_load (can_cap),
    .out_valid(rd_valid),
    .out_data (rd_data)
  );

  // memory port, handshakes, address stepping and next-state decode
  always_comb begin
    in_range = word_in_range(addr_q, MEM_WORDS);
    cap = (state_q == LOAD) && (rem_q != '0) && can_cap;
    step = cap || ((state_q == STORE) && wd_valid);
    cap_data = in_range ? mem_RD : '0;
    req_ready = state_q == IDLE;
    wd_ready = state_q == STORE;
    done = state_q == DONE;
    err = err_q;
    mem_A = (state_q == LOAD || state_q == STORE) ? addr_q : '0;
    mem_WD = (state_q == STORE) ? wd_data : '0;
    mem_WE = rst_n && (state_q == STORE) && wd_valid && in_range;
    state_d = state_q;
    addr_d = step ? addr_q + {22'b0, stride_q, 2'b00} : addr_q;
    rem_d = step ? rem_q - LEN_W'(1) : rem_q;
    stride_d = stride_q;
    err_d = err_q || (step && !in_range);
    if (state_q == IDLE && req_valid) begin
      addr_d = req_base & 32'hFFFF_FFFC;
      rem_d = req_len;
      stride_d = req_stride;
      err_d = 1'b0;
      state_d = (req_len == '0) ? DONE : req_write ? STORE : LOAD;
    end else if (state_q == STORE && wd_valid && rem_q == LEN_W'(1)) begin
      state_d = DONE;
    end else if (state_q == LOAD && rem_q == '0 && (!rd_valid || rd_ready)) begin
      state_d = DONE;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end

  // sequencer state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      rem_q <= '0;
      stride_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
      stride_q <= stride_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_vec_mem_seq.sv
// tb_vec_mem_seq: directed scenarios for the burst sequencer against a 102-word memory model
module tb_vec_mem_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_base = '0;
  logic [7:0]  req_len = '0;
  logic [7:0]  req_stride = '0;
  logic        wd_valid = 1'b0;
  logic [47:0] wd_data = '0;
  logic        rd_ready = 1'b0;
  logic        req_ready, wd_ready, rd_valid, done, err, mem_WE;
  logic [47:0] rd_data, mem_WD, mem_RD;
  logic [31:0] mem_A;

  logic [47:0] mem [0:101];
  logic        mem_init = 1'b1;
  logic        mem_ok;
  int          errors = 0;
  int          checks = 0;
  int          done_n = 0;
  logic [31:0] aq[$];
  logic [47:0] wq[$];
  logic [47:0] rq[$];
  logic [47:0] got[9];
  string       rst_nm[9] = '{"req_ready", "wd_ready", "rd_valid", "rd_data", "done", "err", "mem_WE", "mem_A", "mem_WD"};
  logic [47:0] rst_want[9] = '{48'd1, 48'd0, 48'd0, 48'd0, 48'd0, 48'd0, 48'd0, 48'd0, 48'd0};

  localparam logic [47:0] D0 = 48'h010203040506;
  localparam logic [47:0] D1 = 48'h010203040507;
  localparam logic [47:0] D2 = 48'h010203040508;
  localparam logic [47:0] W7 = 48'h070707070707;
  localparam logic [47:0] GARBAGE = 48'hDEADBEEFCAFE;

  vec_mem_seq dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_base(req_base), .req_len(req_len), .req_stride(req_stride),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done), .err(err), .mem_A(mem_A), .mem_WE(mem_WE), .mem_WD(mem_WD), .mem_RD(mem_RD)
  );

  always #5 clk = ~clk;

  // combinational-read memory; out-of-range reads return garbage the DUT must zero
  assign mem_ok = (mem_A[31:14] == '0) && (mem_A[13:2] < 12'd102);
  assign mem_RD = mem_ok ? mem[mem_A[13:2]] : GARBAGE;

  // word i initially holds byte i in every lane
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 102; i++) mem[i] <= {6{8'(i)}};
      mem_init <= 1'b0;
    end else if (mem_WE && mem_ok) begin
      mem[mem_A[13:2]] <= mem_WD;
    end
  end

  task automatic step();
    #1;
    if (mem_WE) begin
      aq.push_back(mem_A);
      wq.push_back(mem_WD);
    end
    if (rd_valid && rd_ready) rq.push_back(rd_data);
    if (done) done_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    aq.delete();
    wq.delete();
    rq.delete();
    done_n = 0;
  endtask

  task automatic request(input logic w, input logic [31:0] base, input logic [7:0] len, input logic [7:0] stride);
    req_valid = 1'b1;
    req_write = w;
    req_base = base;
    req_len = len;
    req_stride = stride;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wd_valid = 1'b1;
    wd_data = D0;
    rd_ready = 1'b1;
    step();
    step();
    #1;
    got = '{48'(req_ready), 48'(wd_ready), 48'(rd_valid), rd_data, 48'(done), 48'(err), 48'(mem_WE), 48'(mem_A), mem_WD};
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (got[i] !== rst_want[i]) begin
        errors++;
        $display("FAIL reset_%s: got %h want %h", rst_nm[i], got[i], rst_want[i]);
      end
    end
    rst_n = 1'b1;
    wd_valid = 1'b0;
    rd_ready = 1'b0;
    step();
  endtask

  task automatic test_store();
    logic [47:0] dv[3] = '{D0, D1, D2};
    clear_logs();
    wd_valid = 1'b1;
    wd_data = D0;
    request(1'b1, 32'h10, 8'd3, 8'd1);
    for (int i = 0; i < 3; i++) begin
      wd_data = dv[i];
      #1;
      checks++;
      if (mem_WE !== 1'b1 || mem_A !== 32'h10 + 32'(4*i)) begin
        errors++;
        $display("FAIL store_beat%0d: got we=%b a=%h want we=1 a=%h", i, mem_WE, mem_A, 32'h10 + 32'(4*i));
      end
      step();
    end
    wd_valid = 1'b0;
    #1;
    checks++;
    if (done !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL store_done: got done=%b err=%b want done=1 err=0", done, err);
    end
    step();
    checks++;
    if (done !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL store_idle: got done=%b req_ready=%b want 0 1", done, req_ready);
    end
    checks++;
    if (aq.size() != 3 || done_n != 1 || mem[4] !== D0 || mem[5] !== D1 || mem[6] !== D2) begin
      errors++;
      $display("FAIL store_totals: got writes=%0d dones=%0d w4=%h w5=%h w6=%h want 3 1 %h %h %h", aq.size(), done_n, mem[4], mem[5], mem[6], D0, D1, D2);
    end
  endtask

  task automatic test_load();
    logic [47:0] dv[3] = '{D0, D1, D2};
    clear_logs();
    rd_ready = 1'b1;
    request(1'b0, 32'h10, 8'd3, 8'd1);
    #1;
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL load_first_cycle: got rd_valid=%b want 0", rd_valid);
    end
    step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== dv[i]) begin
        errors++;
        $display("FAIL load_beat%0d: got v=%b d=%h want v=1 d=%h", i, rd_valid, rd_data, dv[i]);
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || rd_valid !== 1'b0 || rq.size() != 3 || err !== 1'b0) begin
      errors++;
      $display("FAIL load_done: got done=%b v=%b beats=%0d err=%b want 1 0 3 0", done, rd_valid, rq.size(), err);
    end
    step();
  endtask

  task automatic test_back_pressure();
    logic [47:0] ev[4] = '{D0, D1, D2, W7};
    clear_logs();
    rd_ready = 1'b1;
    request(1'b0, 32'h10, 8'd4, 8'd1);
    for (int k = 0; k < 8; k++) begin
      rd_ready = (k < 2) || (k > 4);
      #1;
      if (k >= 2 && k <= 4) begin
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== D1 || mem_A !== 32'h18) begin
          errors++;
          $display("FAIL stall_k%0d: got v=%b d=%h a=%h want v=1 d=%h a=00000018", k, rd_valid, rd_data, mem_A, D1);
        end
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || done_n != 0) begin
      errors++;
      $display("FAIL stall_done: got done=%b earlier=%0d want 1 0", done, done_n);
    end
    step();
    checks++;
    if (rq.size() != 4) begin
      errors++;
      $display("FAIL stall_count: got %0d want 4", rq.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rq[i] !== ev[i]) begin
        errors++;
        $display("FAIL stall_beat%0d: got %h want %h", i, rq[i], ev[i]);
      end
    end
  endtask

  task automatic test_store_oor();
    logic [47:0] dv[3] = '{48'hA0A0A0A0A0A0, 48'hA1A1A1A1A1A1, 48'hA2A2A2A2A2A2};
    clear_logs();
    wd_valid = 1'b1;
    wd_data = dv[0];
    request(1'b1, 32'h190, 8'd3, 8'd1);
    for (int i = 0; i < 3; i++) begin
      wd_data = dv[i];
      #1;
      if (i == 1) begin
        checks++;
        if (err !== 1'b0) begin
          errors++;
          $display("FAIL oor_err_early: got %b want 0", err);
        end
      end
      if (i == 2) begin
        checks++;
        if (mem_WE !== 1'b0 || mem_A !== 32'h198 || wd_ready !== 1'b1) begin
          errors++;
          $display("FAIL oor_suppress: got we=%b a=%h rdy=%b want 0 00000198 1", mem_WE, mem_A, wd_ready);
        end
      end
      step();
    end
    wd_valid = 1'b0;
    #1;
    checks++;
    if (err !== 1'b1 || done !== 1'b1) begin
      errors++;
      $display("FAIL oor_err_set: got err=%b done=%b want 1 1", err, done);
    end
    step();
    step();
    step();
    checks++;
    if (err !== 1'b1 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL oor_err_sticky: got err=%b req_ready=%b want 1 1", err, req_ready);
    end
    checks++;
    if (aq.size() != 2 || mem[100] !== dv[0] || mem[101] !== dv[1]) begin
      errors++;
      $display("FAIL oor_writes: got n=%0d w100=%h w101=%h want 2 %h %h", aq.size(), mem[100], mem[101], dv[0], dv[1]);
    end
  endtask

  task automatic test_load_oor();
    clear_logs();
    rd_ready = 1'b1;
    request(1'b0, 32'h196, 8'd2, 8'd1);
    #1;
    checks++;
    if (err !== 1'b0 || mem_A !== 32'h194) begin
      errors++;
      $display("FAIL ld_oor_accept: got err=%b a=%h want 0 00000194", err, mem_A);
    end
    step();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 48'hA1A1A1A1A1A1) begin
      errors++;
      $display("FAIL ld_oor_beat0: got v=%b d=%h want 1 a1a1a1a1a1a1", rd_valid, rd_data);
    end
    step();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 48'h0 || err !== 1'b1) begin
      errors++;
      $display("FAIL ld_oor_beat1: got v=%b d=%h err=%b want 1 0 1", rd_valid, rd_data, err);
    end
    step();
    step();
  endtask

  task automatic test_zero_len();
    for (int w = 0; w < 2; w++) begin
      clear_logs();
      wd_valid = 1'b1;
      rd_ready = 1'b1;
      request(w[0], 32'h10, 8'd0, 8'd1);
      #1;
      checks++;
      if (req_ready !== 1'b0 || done !== 1'b1 || err !== 1'b0) begin
        errors++;
        $display("FAIL zero_len%0d_done: got rdy=%b done=%b err=%b want 0 1 0", w, req_ready, done, err);
      end
      step();
      checks++;
      if (req_ready !== 1'b1 || done !== 1'b0 || aq.size() != 0 || rq.size() != 0) begin
        errors++;
        $display("FAIL zero_len%0d_after: got rdy=%b done=%b writes=%0d reads=%0d want 1 0 0 0", w, req_ready, done, aq.size(), rq.size());
      end
      wd_valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid_burst();
    clear_logs();
    rd_ready = 1'b0;
    wd_valid = 1'b1;
    wd_data = 48'hC0C0C0C0C0C0;
    request(1'b1, 32'h0, 8'd8, 8'd2);
    for (int i = 0; i < 3; i++) begin
      wd_data = {6{8'hC0 + 8'(i)}};
      step();
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_WE !== 1'b0) begin
      errors++;
      $display("FAIL midrst_we: got %b want 0", mem_WE);
    end
    step();
    rst_n = 1'b1;
    #1;
    got = '{48'(req_ready), 48'(wd_ready), 48'(rd_valid), rd_data, 48'(done), 48'(err), 48'(mem_WE), 48'(mem_A), mem_WD};
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (got[i] !== rst_want[i]) begin
        errors++;
        $display("FAIL midrst_%s: got %h want %h", rst_nm[i], got[i], rst_want[i]);
      end
    end
    step();
    step();
    checks++;
    if (aq.size() != 3 || done_n != 0 || mem[6] !== D2 || mem[4] !== 48'hC2C2C2C2C2C2) begin
      errors++;
      $display("FAIL midrst_effects: got writes=%0d dones=%0d w6=%h w4=%h want 3 0 %h c2c2c2c2c2c2", aq.size(), done_n, mem[6], mem[4], D2);
    end
    wd_data = 48'hE1E2E3E4E5E6;
    request(1'b1, 32'h20, 8'd1, 8'd1);
    #1;
    checks++;
    if (mem_WE !== 1'b1 || mem_A !== 32'h20) begin
      errors++;
      $display("FAIL midrst_new_req: got we=%b a=%h want 1 00000020", mem_WE, mem_A);
    end
    step();
    wd_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || mem[8] !== 48'hE1E2E3E4E5E6) begin
      errors++;
      $display("FAIL midrst_new_done: got done=%b w8=%h want 1 e1e2e3e4e5e6", done, mem[8]);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_back_pressure();
    test_store_oor();
    test_load_oor();
    test_zero_len();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
